// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: run handshake plus fetch bus between the sequencer, register file, ROM and testbench.
interface fetch_sequencer_if;
  logic        req;
  logic [1:0]  prog_sel;
  logic [9:0]  rp;
  logic [8:0]  rom_data;
  logic        start;
  logic [9:0]  start_addr;
  logic [9:0]  rom_addr;
  logic [8:0]  instr;
  logic        instr_valid;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;
  modport master (
    output req, prog_sel, rp, rom_data,
    input  start, start_addr, rom_addr, instr, instr_valid, done, timeout, cycle_count
  );
  modport slave (
    input  req, prog_sel, rp, rom_data,
    output start, start_addr, rom_addr, instr, instr_valid, done, timeout, cycle_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program-level load/run/halt sequencer with cycle counter and watchdog.
module fetch_sequencer #(
  parameter logic [9:0]  PROG0_ADDR  = 10'h000,
  parameter logic [9:0]  PROG1_ADDR  = 10'h100,
  parameter logic [9:0]  PROG2_ADDR  = 10'h200,
  parameter logic [9:0]  PROG3_ADDR  = 10'h300,
  parameter int          LOAD_CYCLES = 2,
  parameter logic [8:0]  HALT_OP     = 9'h1FF,
  parameter logic [8:0]  NOP_OP      = 9'h000,
  parameter logic [15:0] MAX_CYCLES  = 16'hFFF0
) (
  input logic clk,
  input logic rst_n,
  fetch_sequencer_if.slave bus
);
  localparam int LW = $clog2(LOAD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [1:0] sel;
  logic [LW-1:0] load_cnt;
  logic [15:0] cnt;
  logic to;
  logic run, halt, wd;
  logic [9:0] addr;
  assign run  = state == RUN;
  assign halt = run && bus.rom_data == HALT_OP;
  assign wd   = cnt == MAX_CYCLES - 16'd1;
  assign addr = sel == 2'd0 ? PROG0_ADDR :
                sel == 2'd1 ? PROG1_ADDR :
                sel == 2'd2 ? PROG2_ADDR : PROG3_ADDR;
  assign bus.start       = !run;
  assign bus.start_addr  = addr;
  assign bus.rom_addr    = run ? bus.rp : addr;
  assign bus.instr       = run ? bus.rom_data : NOP_OP;
  assign bus.instr_valid = run;
  assign bus.done        = state == DONE;
  assign bus.timeout     = to;
  assign bus.cycle_count = cnt;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.req ? LOAD : IDLE;
      LOAD:    state_n = !bus.req ? IDLE : load_cnt == '0 ? RUN : LOAD;
      RUN:     state_n = !bus.req ? IDLE : (halt || wd) ? DONE : RUN;
      DONE:    state_n = bus.req ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      load_cnt <= '0;
      cnt      <= 16'd0;
      to       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req) begin
        sel      <= bus.prog_sel;
        load_cnt <= LW'(LOAD_CYCLES - 1);
        cnt      <= 16'd0;
        to       <= 1'b0;
      end
      if (state == LOAD && load_cnt != '0) load_cnt <= load_cnt - 1'b1;
      if (run) begin
        cnt <= cnt == 16'hFFFF ? cnt : cnt + 16'd1;
        // halt outranks the watchdog, and an abort sets neither
        if (bus.req && !halt && wd) to <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plus randomized run traffic against a transaction-level model.
module tb_fetch_sequencer;
  localparam int LC   = 2;
  localparam int MAXC = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fetch_sequencer_if bus();
  logic [8:0] rom [1024];
  int n_tests = 0;
  int n_fail = 0;
  bit m_active, m_fin, m_to;
  int m_loaded, m_cnt;
  logic [1:0] m_sel;
  assign bus.rom_data = rom[bus.rom_addr];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bus.rp <= 10'd0;
    else bus.rp <= bus.start ? bus.start_addr : bus.rp + 10'd1;
  fetch_sequencer #(.MAX_CYCLES(16'(MAXC))) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] nh();
    return 9'($urandom_range(0, 9'h1FE));
  endfunction
  function automatic bit m_running();
    return m_active && m_loaded == LC && !m_fin;
  endfunction
  task automatic m_reset();
    m_active = 0; m_fin = 0; m_to = 0; m_loaded = 0; m_cnt = 0; m_sel = 2'd0;
  endtask
  task automatic check_all();
    bit r;
    logic [9:0] sa;
    r  = m_running();
    sa = {m_sel, 8'h00};
    chk("start", bus.start, !r);
    chk("start_addr", bus.start_addr, sa);
    chk("rom_addr", bus.rom_addr, r ? bus.rp : sa);
    chk("instr", bus.instr, r ? rom[bus.rp] : 9'h000);
    chk("instr_valid", bus.instr_valid, r);
    chk("done", bus.done, m_active && m_fin);
    chk("timeout", bus.timeout, m_to);
    chk("cycle_count", bus.cycle_count, m_cnt);
  endtask
  task automatic model_adv();
    bit wd;
    if (!m_active) begin
      if (bus.req) begin
        m_active = 1; m_loaded = 0; m_fin = 0; m_sel = bus.prog_sel; m_cnt = 0; m_to = 0;
      end
    end else if (!bus.req) begin
      if (m_running()) m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535;
      m_active = 0;
      m_fin = 0;
    end else if (!m_fin) begin
      if (m_loaded < LC) m_loaded++;
      else begin
        wd = m_cnt == MAXC - 1;
        m_cnt = m_cnt < 65535 ? m_cnt + 1 : 65535;
        if (rom[bus.rp] == 9'h1FF) m_fin = 1;
        else if (wd) begin m_fin = 1; m_to = 1; end
      end
    end
  endtask
  task automatic cyc(input bit r, input logic [1:0] ps);
    bus.req = r;
    bus.prog_sel = ps;
    #1;
    check_all();
    model_adv();
    @(posedge clk);
    #1;
  endtask
  task automatic run_prog(input logic [1:0] ps, input int limit);
    int n = 0;
    cyc(1, ps);
    while (!bus.done && n < limit) begin
      cyc(1, ps);
      n++;
    end
    chk("run_bound", bus.done, 1);
  endtask
  initial begin
    bus.req = 0;
    bus.prog_sel = 2'd0;
    for (int i = 0; i < 1024; i++) rom[i] = nh();
    rom[10'h200] = 9'h012; rom[10'h201] = 9'h034; rom[10'h202] = 9'h1FF;
    rom[10'h10F] = 9'h1FF;
    m_reset();
    #3;
    chk("rst_start", bus.start, 1);
    chk("rst_start_addr", bus.start_addr, 10'h000);
    chk("rst_instr", bus.instr, 9'h000);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_count", bus.cycle_count, 0);
    @(negedge clk);
    rst_n = 1;
    cyc(0, 0);
    run_prog(2, 20);
    chk("halt_count", bus.cycle_count, 3);
    chk("halt_timeout", bus.timeout, 0);
    chk("halt_instr", bus.instr, 9'h000);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1);
      chk("done_hold", bus.done, 1);
    end
    cyc(0, 1);
    chk("done_clear", bus.done, 0);
    cyc(1, 0);
    chk("restart_count", bus.cycle_count, 0);
    cyc(0, 0);
    run_prog(3, 40);
    chk("wd_count", bus.cycle_count, 16);
    chk("wd_timeout", bus.timeout, 1);
    cyc(0, 0);
    run_prog(1, 40);
    chk("halt16_count", bus.cycle_count, 16);
    chk("halt16_timeout", bus.timeout, 0);
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    chk("load_abort_start", bus.start, 1);
    chk("load_abort_done", bus.done, 0);
    for (int i = 0; i < 7; i++) cyc(1, 3);
    cyc(0, 3);
    chk("run_abort_count", bus.cycle_count, 5);
    chk("run_abort_start", bus.start, 1);
    chk("run_abort_done", bus.done, 0);
    for (int i = 0; i < 6; i++) cyc(1, 3);
    #2;
    rst_n = 0;
    #1;
    chk("async_start", bus.start, 1);
    chk("async_instr", bus.instr, 9'h000);
    chk("async_count", bus.cycle_count, 0);
    chk("async_valid", bus.instr_valid, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 1024; i++)
      rom[i] = (i >= 10'h300 || $urandom_range(0, 9) != 0) ? nh() : 9'h1FF;
    begin
      bit r = 0;
      for (int i = 0; i < 4000; i++) begin
        r = r ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 2) == 0);
        cyc(r, 2'($urandom));
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-level sequencer that sits directly upstream of the register file and owns the fetch side of the 9-bit core. It generates the `start` hold signal and the per-program start address, and drives the instruction-memory address from the register file's 10-bit PC (`rp`). It gates fetched instructions into the decoder, detects the halt opcode and reports completion to the testbench through a req/done handshake. It also counts executed cycles and enforces a watchdog limit.

Parameters:
PROG0_ADDR, 10'h000, start address for program 0
PROG1_ADDR, 10'h100, start address for program 1
PROG2_ADDR, 10'h200, start address for program 2
PROG3_ADDR, 10'h300, start address for program 3
LOAD_CYCLES, 2, cycles `start` is held high after a request before execution begins (≥1)
HALT_OP, 9'h1FF, instruction encoding that ends a program
NOP_OP, 9'h000, encoding injected into the decoder when not running
MAX_CYCLES, 16'hFFF0, watchdog limit on RUN cycles

Ports:
clk  in  1  system clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
req  in  1  run request from testbench; level-sensitive, held high for a whole run
prog_sel  in  2  program select; sampled only on IDLE->LOAD
rp  in  10  current PC from register file
rom_data  in  9  instruction memory read data (asynchronous read of rom_addr)
start  out  1  to register file; high forces PC to start_addr
start_addr  out  10  selected program start address
rom_addr  out  10  instruction memory address
instr  out  9  instruction to decoder
instr_valid  out  1  high when instr is a live fetched instruction
done  out  1  run finished; held until req falls
timeout  out  1  run ended by watchdog, valid while done=1
cycle_count  out  16  RUN cycles of the current/last run

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Encoding is free.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, start=1, done=0, timeout=0, cycle_count=0, load counter=0, prog_sel latch=0.
  - start_addr=PROG0_ADDR, instr=NOP_OP, instr_valid=0.
- Combinational outputs:
  - start_addr = PROGn_ADDR for the latched selection.
  - rom_addr = rp in RUN, otherwise start_addr.
  - instr = rom_data in RUN, otherwise NOP_OP.
  - instr_valid = (state==RUN).
  - start = 1 in all states except RUN.
- IDLE:
  - req=1 -> LOAD.
  - On this transition: latch prog_sel, load counter=LOAD_CYCLES-1, clear cycle_count and timeout.
- LOAD:
  - Counter decrements each cycle.
  - Counter==0 and req=1 -> RUN, so LOAD lasts exactly LOAD_CYCLES cycles.
  - req=0 -> IDLE (abort).
- RUN:
  - Each posedge increments cycle_count; it saturates at 16'hFFFF.
  - Priority, highest first:
    1. req=0 -> IDLE (abort; cycle_count retained).
    2. instr==HALT_OP -> DONE. The halt cycle is counted.
    3. cycle_count==MAX_CYCLES-1 at the posedge -> DONE with timeout=1.
  - If halt and watchdog coincide on the same cycle, the result is timeout=0 (halt wins).
- DONE:
  - done=1; cycle_count and timeout frozen.
  - req=0 -> IDLE; done falls on the same edge.
  - req held high keeps DONE indefinitely. No restart without req first going low.
- PC wrap: rp 10'h3FF -> 10'h000 is passed through unmodified; the block does not police it.
- rst_n asserted in any state returns to reset values immediately. Release takes effect on the next posedge with state=IDLE.
- prog_sel changes outside the IDLE->LOAD edge are ignored.

Test Plan:
1. Reset, then req=1 with prog_sel=2.
   -> start=1 for 2 cycles with start_addr=10'h200 and rom_addr=10'h200.
   -> Then start=0, instr_valid=1, rom_addr follows rp.
2. Program whose rom_data is 9'h012, 9'h034, then 9'h1FF at rp=0x200..0x202.
   -> instr shows each word in turn.
   -> DONE after 3 RUN cycles with cycle_count=3, done=1, timeout=0, instr=NOP_OP.
3. Hold req=1 in DONE for 10 cycles, then drop it.
   -> done stays 1 for the 10 cycles and clears on the edge req=0 is seen.
   -> State IDLE; a new req restarts with cycle_count cleared.
4. MAX_CYCLES=16 with no halt word.
   -> DONE after exactly 16 RUN cycles with timeout=1, cycle_count=16.
   -> Separately, with HALT_OP on the 16th cycle: timeout=0.
5. Drop req at LOAD cycle 1, and again at RUN cycle 5.
   -> Return to IDLE next edge, start=1, done never asserts.
   -> After the RUN abort, cycle_count=5 is retained.
6. Pulse rst_n low mid-RUN, between clock edges.
   -> Outputs go to reset values immediately (start=1, instr=NOP_OP, cycle_count=0) without waiting for clk.
